pipeline_out_fifo: RTL and testbench

//  Output buffer directly downstream of the 3-stage pipeline unit.
//  - Absorbs its data/valid stream, which has no backpressure.
//  - Presents a valid/ready handshake to the consumer.
//  - almost_full lets control logic stall the producer before the 3 words in flight are lost.
//  - Flush is secure, like the upstream stages: every stored word is zeroed.

---
 rtl/pipeline_out_fifo.sv | 130 +++++++++++++
 tb/tb_pipeline_out_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_out_fifo.sv
// Output FIFO behind the 3-stage pipeline: absorbs a stream with no backpressure,
// presents valid/ready to the consumer, and zeroes storage on pop and on flush.
//
// Ports:
//   clk, reset      clock (rising edge), asynchronous active-high reset
//   in_data/valid   producer stream from pipeline stage 3, no backpressure
//   flush           secure flush shared with upstream: gates valid, zeroes storage
//   out_data/valid  head-of-queue word (first-word fall-through, registered)
//   out_ready       consumer accepts the head when out_valid && out_ready
//   count           number of stored words
//   full            count == DEPTH
//   almost_full     count >= DEPTH - AFULL_MARGIN
//   overflow        sticky drop flag; cleared by err_clear or reset
//   err_clear       clears overflow, unless a drop happens in the same cycle
module pipeline_out_fifo #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    input  logic                       flush,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       almost_full,
    output logic                       overflow,
    input  logic                       err_clear
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(DEPTH - AFULL_MARGIN);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic              overflow_q;

    logic push;
    logic pop;
    logic drop;

    // Flags come from the count register only.
    assign full        = (count_q == DEPTH_C);
    assign almost_full = (count_q >= AFULL_C);

    assign out_valid = (count_q != '0) && !flush;
    assign out_data  = mem[rd_ptr];

    assign pop  = out_valid && out_ready;
    assign push = in_valid && !flush && (!full || pop);
    assign drop = in_valid && !flush && full && !pop;

    assign count    = count_q;
    assign overflow = overflow_q;

    // Storage. When full, push and pop hit the same slot; the
    // incoming word must win over the zeroing of the popped one,
    // so the push write comes last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (pop) begin
                mem[rd_ptr] <= '0;
            end
            if (push) begin
                mem[wr_ptr] <= in_data;
            end
        end
    end

    // Pointers wrap naturally: DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Flush leaves the sticky error alone; a drop beats err_clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (err_clear) begin
            overflow_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipeline_out_fifo.sv
// Directed bench for pipeline_out_fifo (DATA_W=32, DEPTH=8, AFULL_MARGIN=3).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_pipeline_out_fifo;

    logic        clk;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        flush;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  count;
    logic        full;
    logic        almost_full;
    logic        overflow;
    logic        err_clear;

    int total = 0;
    int bad   = 0;

    pipeline_out_fifo #(
        .DATA_W(32),
        .DEPTH(8),
        .AFULL_MARGIN(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .flush(flush),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count(count),
        .full(full),
        .almost_full(almost_full),
        .overflow(overflow),
        .err_clear(err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        err_clear = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        step();
        reset = 1'b0;
        step();

        // Empty: out_ready ignored, no underflow.
        out_ready = 1'b1;
        step();
        chk("empty_count", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Basic push then drain.
        push(32'hA1);
        chk("lat1_data", out_data, 32'hA1);
        chk("lat1_valid", 32'(out_valid), 32'd1);
        push(32'hA2);
        push(32'hA3);
        chk("t2_count", 32'(count), 32'd3);
        chk("t2_head", out_data, 32'hA1);
        out_ready = 1'b1;
        chk("t2_pop0", out_data, 32'hA1);
        step();
        chk("t2_pop1", out_data, 32'hA2);
        step();
        chk("t2_pop2", out_data, 32'hA3);
        step();
        out_ready = 1'b0;
        chk("t2_empty_valid", 32'(out_valid), 32'd0);
        chk("t2_empty_data", out_data, 32'd0);
        chk("t2_empty_count", 32'(count), 32'd0);

        // Fill: almost_full at 5, full at 8.
        for (int i = 0; i < 8; i++) begin
            push(32'h10 + 32'(i));
            chk($sformatf("t3_afull_%0d", i + 1), 32'(almost_full),
                32'((i + 1) >= 5));
            chk($sformatf("t3_full_%0d", i + 1), 32'(full),
                32'((i + 1) == 8));
        end
        chk("t3_ovf_pre", 32'(overflow), 32'd0);
        push(32'h18);
        chk("t3_drop_ovf", 32'(overflow), 32'd1);
        chk("t3_drop_count", 32'(count), 32'd8);
        chk("t3_drop_head", out_data, 32'h10);

        // Full, push and pop together.
        in_valid  = 1'b1;
        in_data   = 32'h20;
        out_ready = 1'b1;
        chk("t4_head", out_data, 32'h10);
        step();
        in_valid = 1'b0;
        chk("t4_count", 32'(count), 32'd8);
        chk("t4_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_drain_%0d", i), out_data,
                (i < 7) ? 32'h11 + 32'(i) : 32'h20);
            step();
        end
        out_ready = 1'b0;
        chk("t4_drained", 32'(count), 32'd0);
        chk("t4_drained_data", out_data, 32'd0);

        // Flush with storage wrapping past index 0.
        for (int i = 0; i < 5; i++) begin
            push(32'hB0 + 32'(i));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t5_count_pre", 32'(count), 32'd4);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hEE;
        out_ready = 1'b1;
        #1;
        chk("t5_flush_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_data", out_data, 32'd0);
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_ovf", 32'(overflow), 32'd1);
        push(32'hC0);
        chk("t5_repush_data", out_data, 32'hC0);
        chk("t5_repush_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t5_next_zero", out_data, 32'd0);

        // err_clear.
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("t6_clear", 32'(overflow), 32'd0);

        // Reset mid-stream at count=5, checked before any edge.
        for (int i = 0; i < 5; i++) begin
            push(32'hD0 + 32'(i));
        end
        chk("t1_count_pre", 32'(count), 32'd5);
        reset = 1'b1;
        #1;
        chk("t1_valid", 32'(out_valid), 32'd0);
        chk("t1_data", out_data, 32'd0);
        chk("t1_count", 32'(count), 32'd0);
        chk("t1_ovf", 32'(overflow), 32'd0);
        step();
        reset = 1'b0;
        step();

        // Drop vs err_clear.
        for (int i = 0; i < 8; i++) begin
            push(32'hE0 + 32'(i));
        end
        push(32'h99);
        chk("t6_drop", 32'(overflow), 32'd1);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("t6_clear2", 32'(overflow), 32'd0);
        err_clear = 1'b1;
        push(32'h9A);
        err_clear = 1'b0;
        chk("t6_set_wins", 32'(overflow), 32'd1);
        chk("t6_count", 32'(count), 32'd8);
        chk("t6_head", out_data, 32'hE0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
